// File: rtl/sram_like_if.sv
// sram_like_if
//   The initiator-side bus of the SRAM-like slave: the request channel
//   (req/wr/size/addr/wdata) and the response channel
//   (addr_ok/data_ok/rdata).
//
//   Modports:
//     master  drives the request, observes the handshake and the response
//     slave   observes the request, drives the handshake and the response
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_slave.sv
// sram_like_slave
//   Bridges a pipelined SRAM-like initiator bus onto a synchronous
//   single-port SRAM. The SRAM returns read data one cycle after its enable.
//   Up to DEPTH requests may be outstanding. Responses return in order, each
//   no earlier than 1+WAIT cycles after its request was accepted.
//
//   Parameters:
//     DEPTH  max outstanding requests (power of 2, 2..8)
//     WAIT   extra response latency in cycles (0..7)
//
//   Ports:
//     clk          clock, all state updates on posedge
//     rst          synchronous active-high reset
//     i_bus        sram_like_if.slave: req/wr/size/addr/wdata in,
//                  addr_ok/data_ok/rdata out
//     o_ram_en     SRAM enable, high only in the cycle a request is accepted
//     o_ram_wen    SRAM byte write enables
//     o_ram_addr   word-aligned SRAM address
//     o_ram_wdata  SRAM write data
//     i_ram_rdata  SRAM read data, valid the cycle after o_ram_en
//
//   Build option:
//     SRAM_SLAVE_STALL_EN  when defined, an 8-bit LFSR randomly withholds
//                          addr_ok to exercise initiator back-pressure
module sram_like_slave #(
    parameter int DEPTH = 4,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    sram_like_if.slave  i_bus,
    output logic        o_ram_en,
    output logic [3:0]  o_ram_wen,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_wdata,
    input  logic [31:0] i_ram_rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // An entry's age is 1 in its first cycle in the FIFO. It becomes
    // eligible for response once its age reaches WAIT+1, and it stops there.
    localparam logic [3:0]    AGE_RDY = 4'(WAIT + 1);

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_age   [DEPTH];
    logic          r_is_wr [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    // Slot of the read accepted last cycle, whose SRAM data is on i_ram_rdata now.
    logic          r_cap_vld;
    logic [PW-1:0] r_cap_ptr;

    logic          w_stall;
    logic          w_addr_ok;
    logic          w_accept;
    logic          w_pop;
    logic          w_bypass;
    logic [3:0]    w_lane;
    logic [31:0]   w_rdata;

`ifdef SRAM_SLAVE_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // The registered count is used here, so a pop in this cycle does not free a slot until the next cycle.
    assign w_addr_ok = !rst && (r_count < DEPTH_C) && !w_stall;
    assign w_accept  = i_bus.req && w_addr_ok;
    assign w_pop     = !rst && (r_count != '0) && (r_age[r_rd_ptr] == AGE_RDY);
    // The head was accepted last cycle, so its read data has not been stored yet.
    assign w_bypass  = r_cap_vld && (r_cap_ptr == r_rd_ptr);

    always_comb begin
        case (i_bus.size)
            2'd0:    w_lane = 4'b0001 << i_bus.addr[1:0];
            2'd1:    w_lane = 4'b0011 << {i_bus.addr[1], 1'b0};
            default: w_lane = 4'b1111;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_pop && !r_is_wr[r_rd_ptr]) begin
            w_rdata = w_bypass ? i_ram_rdata : r_data[r_rd_ptr];
        end
    end

    assign o_ram_en    = w_accept;
    assign o_ram_wen   = (w_accept && i_bus.wr) ? w_lane : 4'b0000;
    assign o_ram_addr  = {i_bus.addr[31:2], 2'b00};
    assign o_ram_wdata = i_bus.wdata;

    assign i_bus.addr_ok = w_addr_ok;
    assign i_bus.data_ok = w_pop;
    assign i_bus.rdata   = w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cap_vld <= 1'b0;
            r_cap_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= 4'd0;
            end
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            r_cap_vld <= w_accept && !i_bus.wr;
            r_cap_ptr <= r_wr_ptr;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && (r_wr_ptr == PW'(i))) begin
                    r_age[i] <= 4'd1;
                end else if (r_age[i] != AGE_RDY) begin
                    r_age[i] <= r_age[i] + 4'd1;
                end
            end
        end
    end

    // The payload needs no reset, because a slot is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_wr[r_wr_ptr] <= i_bus.wr;
        end
        if (r_cap_vld) begin
            r_data[r_cap_ptr] <= i_ram_rdata;
        end
    end
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave
//   Drives two slaves from the same stimulus: index 0 has WAIT=0 and index 1
//   has WAIT=3, and both have DEPTH=4. Each slave has its own SRAM. A
//   behavioural model keeps a list of pending responses and their due cycles,
//   plus a shadow memory. One compare process checks every output of both
//   slaves on every cycle. Directed sequences also pin hand-computed literals.
module tb_sram_like_slave;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        tb_req;
    logic        tb_wr;
    logic [1:0]  tb_size;
    logic [31:0] tb_addr;
    logic [31:0] tb_wdata;

    sram_like_if bus0 ();
    sram_like_if bus3 ();

    logic        ram_en    [2];
    logic [3:0]  ram_wen   [2];
    logic [31:0] ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];

    logic        aok  [2];
    logic        dok  [2];
    logic [31:0] rdat [2];

    assign bus0.req = tb_req;  assign bus3.req = tb_req;
    assign bus0.wr = tb_wr;    assign bus3.wr = tb_wr;
    assign bus0.size = tb_size; assign bus3.size = tb_size;
    assign bus0.addr = tb_addr; assign bus3.addr = tb_addr;
    assign bus0.wdata = tb_wdata; assign bus3.wdata = tb_wdata;
    assign aok[0] = bus0.addr_ok; assign aok[1] = bus3.addr_ok;
    assign dok[0] = bus0.data_ok; assign dok[1] = bus3.data_ok;
    assign rdat[0] = bus0.rdata;  assign rdat[1] = bus3.rdata;

    sram_like_slave #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_bus(bus0),
        .o_ram_en(ram_en[0]), .o_ram_wen(ram_wen[0]), .o_ram_addr(ram_addr[0]),
        .o_ram_wdata(ram_wdata[0]), .i_ram_rdata(ram_rdata[0])
    );

    sram_like_slave #(.DEPTH(DEPTH), .WAIT(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_bus(bus3),
        .o_ram_en(ram_en[1]), .o_ram_wen(ram_wen[1]), .o_ram_addr(ram_addr[1]),
        .o_ram_wdata(ram_wdata[1]), .i_ram_rdata(ram_rdata[1])
    );

    // Synchronous SRAMs, 256 words each.
    logic [31:0] mem  [2][256];
    logic [31:0] rd_q [2];

    for (genvar g = 0; g < 2; g++) begin : g_ram
        assign ram_rdata[g] = rd_q[g];
        always @(posedge clk) begin
            if (ram_en[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen[g][b]) mem[g][ram_addr[g][9:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
                end
                rd_q[g] <= mem[g][ram_addr[g][9:2]];
            end
        end
    end

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'h5A, 8'hC3, ~b};
    endfunction

    // Model state.
    int unsigned m_due  [2][16];
    logic [31:0] m_dat  [2][16];
    int          m_head [2];
    int          m_cnt  [2];
    logic [31:0] shadow [2][256];
    int unsigned cyc = 0;
    int          acc_cnt [2];
    int          dok_cnt [2];
`ifdef SRAM_SLAVE_STALL_EN
    logic [7:0]  m_lfsr = 8'h00;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic        stall;
        logic        exp_aok;
        logic        acc;
        logic        exp_dok;
        logic [3:0]  exp_wen;
        int          nbytes;
        int          first;
        int          slot;
        int          wait_k;
        logic [7:0]  w;
        stall = 1'b0;
`ifdef SRAM_SLAVE_STALL_EN
        stall = m_lfsr[0];
`endif
        nbytes = 1 << tb_size;
        first  = (int'(tb_addr) % 4) / nbytes * nbytes;
        w      = tb_addr[9:2];
        for (int k = 0; k < 2; k++) begin
            wait_k  = (k == 0) ? 0 : 3;
            exp_aok = !rst && (m_cnt[k] < DEPTH) && !stall;
            acc     = tb_req && exp_aok;
            exp_wen = (acc && tb_wr) ? 4'(((1 << nbytes) - 1) << first) : 4'b0000;
            exp_dok = !rst && (m_cnt[k] > 0) && (m_due[k][m_head[k]] <= cyc);
            chk($sformatf("addr_ok[%0d]", k), 32'(aok[k]), 32'(exp_aok));
            chk($sformatf("ram_en[%0d]", k), 32'(ram_en[k]), 32'(acc));
            chk($sformatf("ram_wen[%0d]", k), 32'(ram_wen[k]), 32'(exp_wen));
            if (acc) begin
                chk($sformatf("ram_addr[%0d]", k), ram_addr[k], tb_addr & 32'hFFFF_FFFC);
                chk($sformatf("ram_wdata[%0d]", k), ram_wdata[k], tb_wdata);
            end
            chk($sformatf("data_ok[%0d]", k), 32'(dok[k]), 32'(exp_dok));
            if (exp_dok) chk($sformatf("rdata[%0d]", k), rdat[k], m_dat[k][m_head[k]]);
            if (rst) chk($sformatf("rdata_rst[%0d]", k), rdat[k], 32'h0);

            if (tb_req && aok[k]) acc_cnt[k]++;
            if (dok[k]) dok_cnt[k]++;

            if (rst) begin
                m_cnt[k]  = 0;
                m_head[k] = 0;
            end else begin
                if (exp_dok) begin
                    m_head[k] = (m_head[k] + 1) % 16;
                    m_cnt[k]--;
                end
                if (acc) begin
                    slot = (m_head[k] + m_cnt[k]) % 16;
                    m_due[k][slot] = cyc + 1 + wait_k;
                    m_dat[k][slot] = tb_wr ? 32'h0 : shadow[k][w];
                    m_cnt[k]++;
                    if (tb_wr) begin
                        for (int b = first; b < first + nbytes; b++) begin
                            shadow[k][w][8*b +: 8] = tb_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
`ifdef SRAM_SLAVE_STALL_EN
        if (rst) m_lfsr = 8'hA5;
        else     m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        cyc++;
    end

    task automatic drive(input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        tb_req   = req;
        tb_wr    = wr;
        tb_size  = size;
        tb_addr  = addr;
        tb_wdata = wdata;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            to_mid();
            to_next();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                mem[k][i]    = init_word(i);
                shadow[k][i] = init_word(i);
            end
            mem[k][8'h40]    = 32'hDEAD_BEEF;
            shadow[k][8'h40] = 32'hDEAD_BEEF;
            m_cnt[k]   = 0;
            m_head[k]  = 0;
            acc_cnt[k] = 0;
            dok_cnt[k] = 0;
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);

        // Reset holds every output low, even with req asserted.
        for (int i = 0; i < 3; i++) begin
            to_mid();
            chk("lit_rst_addr_ok", 32'(aok[0]), 32'h0);
            chk("lit_rst_data_ok", 32'(dok[0]), 32'h0);
            chk("lit_rst_ram_en", 32'(ram_en[0]), 32'h0);
            chk("lit_rst_ram_wen", 32'(ram_wen[0]), 32'h0);
            chk("lit_rst_rdata", rdat[0], 32'h0);
            to_next();
        end
        rst = 1'b0;
        idle(1);

        // Single read with WAIT=0.
        drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_rd_addr_ok", 32'(aok[0]), 32'h1);
        chk("lit_rd_ram_addr", ram_addr[0], 32'h100);
`endif
        to_next();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_rd_data_ok", 32'(dok[0]), 32'h1);
        chk("lit_rd_rdata", rdat[0], 32'hDEAD_BEEF);
`endif
        to_next();
        idle(6);

        // Byte, half and word writes.
        drive(1'b1, 1'b1, 2'd0, 32'h103, 32'hAA00_0000);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_wen_byte", 32'(ram_wen[0]), 32'h8);
`endif
        to_next();
        drive(1'b1, 1'b1, 2'd1, 32'h102, 32'hBBBB_0000);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_wen_half", 32'(ram_wen[0]), 32'hC);
        chk("lit_wr1_data_ok", 32'(dok[0]), 32'h1);
        chk("lit_wr1_rdata", rdat[0], 32'h0);
`endif
        to_next();
        drive(1'b1, 1'b1, 2'd2, 32'h100, 32'h1234_5678);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_wen_word", 32'(ram_wen[0]), 32'hF);
        chk("lit_wr2_data_ok", 32'(dok[0]), 32'h1);
`endif
        to_next();
        drive(1'b1, 1'b1, 2'd0, 32'h105, 32'h0000_CC00);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_wen_byte1", 32'(ram_wen[0]), 32'h2);
        chk("lit_wr3_data_ok", 32'(dok[0]), 32'h1);
`endif
        to_next();
        idle(6);

        // Read back the overwritten word and the partly written word.
        drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        to_mid();
        to_next();
        drive(1'b1, 1'b0, 2'd2, 32'h104, 32'h0);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_rb_word", rdat[0], 32'h1234_5678);
`endif
        to_next();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_rb_byte", rdat[0], 32'h411B_CCBE);
`endif
        to_next();
        idle(6);

        // WAIT=3 instance: the FIFO fills, and a fifth request is held off for one cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd2, 32'h10 + 32'(4 * i), 32'h0);
            to_mid();
`ifndef SRAM_SLAVE_STALL_EN
            chk("lit_fill_addr_ok", 32'(aok[1]), 32'h1);
            chk("lit_fill_data_ok", 32'(dok[1]), 32'h0);
`endif
            to_next();
        end
        drive(1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_full_addr_ok", 32'(aok[1]), 32'h0);
        chk("lit_t4_data_ok", 32'(dok[1]), 32'h1);
        chk("lit_t4_rdata", rdat[1], 32'h045E_C3FB);
`endif
        to_next();
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_t5_addr_ok", 32'(aok[1]), 32'h1);
        chk("lit_t5_rdata", rdat[1], 32'h055F_C3FA);
`endif
        to_next();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_t6_rdata", rdat[1], 32'h065C_C3F9);
`endif
        to_next();
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_t7_rdata", rdat[1], 32'h075D_C3F8);
`endif
        to_next();
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_t8_data_ok", 32'(dok[1]), 32'h0);
`endif
        to_next();
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_t9_data_ok", 32'(dok[1]), 32'h1);
        chk("lit_t9_rdata", rdat[1], 32'h0852_C3F7);
`endif
        to_next();
        idle(6);

        // Reset with two reads outstanding discards them.
        drive(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
        to_mid();
        to_next();
        drive(1'b1, 1'b0, 2'd2, 32'h44, 32'h0);
        to_mid();
        to_next();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_mid();
        to_next();
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 32'h48, 32'h0);
        to_mid();
`ifdef SRAM_SLAVE_STALL_EN
        chk("lit_post_rst_stall", 32'(aok[0]), 32'h0);
`else
        chk("lit_post_rst_addr_ok0", 32'(aok[0]), 32'h1);
        chk("lit_post_rst_addr_ok3", 32'(aok[1]), 32'h1);
`endif
        chk("lit_post_rst_quiet0", 32'(dok[1]), 32'h0);
        to_next();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            to_mid();
            chk("lit_post_rst_quiet", 32'(dok[1]), 32'h0);
            to_next();
        end
        to_mid();
`ifndef SRAM_SLAVE_STALL_EN
        chk("lit_post_rst_data_ok", 32'(dok[1]), 32'h1);
        chk("lit_post_rst_rdata", rdat[1], 32'h1248_C3ED);
`endif
        to_next();
        idle(6);

        // Random traffic with req held high.
        for (int k = 0; k < 2; k++) begin
            acc_cnt[k] = 0;
            dok_cnt[k] = 0;
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                  32'($urandom_range(0, 1023)), $urandom);
            to_mid();
            to_next();
        end
        idle(12);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("accepts_vs_responses[%0d]", k), 32'(dok_cnt[k]), 32'(acc_cnt[k]));
            chk($sformatf("model_drained[%0d]", k), 32'(m_cnt[k]), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
